sum_job_scheduler: RTL

SUM_JOB_SCHEDULER -- requirements
Module: sum_job_scheduler

---
 rtl/sum_job_scheduler_pkg.sv | 20 ++
 rtl/sum_job_scheduler_accum.sv | 58 +++++
 rtl/sum_job_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sum_job_scheduler_pkg.sv
// Shared constants, state encoding and the Y-qualify helper for the sum job scheduler.
package sum_job_scheduler_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned N_W     = 32;
    localparam int unsigned SUM_W   = 64;
    localparam int unsigned ID_W    = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StResult = 2'd2
    } state_e;

    // Y qualifies when Y mod 8 is 2, 4 or 6.
    function automatic logic y_qualifies(input logic [N_W-1:0] y);
        return (y[0] == 1'b0) && (y[1] | y[2]);
    endfunction

endpackage

// File: rtl/sum_job_scheduler_accum.sv
// Accumulator core: Y counter, 64-bit running sum X and the terminate compare.
module sum_accum_core
    import sum_job_scheduler_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic [N_W-1:0]   n_i,
    output logic [N_W-1:0]   y_o,
    output logic [SUM_W-1:0] x_o,
    output logic [SUM_W-1:0] x_nxt_o,
    output logic             last_o
);

    logic [N_W-1:0]   y_q, y_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [SUM_W-1:0] x_q, x_d;
    logic [SUM_W-1:0] x_step;

    assign last_o  = (y_q == n_q);
    assign y_o     = y_q;
    assign x_o     = x_q;
    assign x_nxt_o = x_step;

    // Next-state: clear latches a new bound; step accumulates and advances Y until last.
    always_comb begin
        x_step = y_qualifies(y_q) ? (x_q + {{(SUM_W - N_W){1'b0}}, y_q}) : x_q;
        y_d    = y_q;
        x_d    = x_q;
        n_d    = n_q;
        if (clear_i) begin
            y_d = '0;
            x_d = '0;
            n_d = n_i;
        end else if (step_i) begin
            x_d = x_step;
            // Holding Y at N keeps N = all-ones from wrapping.
            if (!last_o) begin
                y_d = y_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            y_q <= '0;
            x_q <= '0;
            n_q <= '0;
        end else begin
            y_q <= y_d;
            x_q <= x_d;
            n_q <= n_d;
        end
    end

endmodule

// File: rtl/sum_job_scheduler.sv
// Round-robin job scheduler: arbitrates requesters, runs one sum job, holds result until ack.
module sum_job_scheduler
    import sum_job_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*N_W-1:0] n_bus,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic [SUM_W-1:0]       res_sum,
    input  logic                   res_ack
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic             first_q, first_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [SUM_W-1:0] res_sum_q, res_sum_d;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  idx;
    logic [N_W-1:0]   win_n;

    logic             core_clear;
    logic             core_step;
    logic             core_last;
    logic [N_W-1:0]   core_y;
    logic [SUM_W-1:0] core_x;
    logic [SUM_W-1:0] core_x_nxt;

    // Round-robin pick: search from last served + 1, wrapping mod NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = last_q + ID_W'(k + 1);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        win_n = n_bus[winner*N_W +: N_W];
    end

    sum_accum_core u_core (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (core_clear),
        .step_i  (core_step),
        .n_i     (win_n),
        .y_o     (core_y),
        .x_o     (core_x),
        .x_nxt_o (core_x_nxt),
        .last_o  (core_last)
    );

    // FSM next-state and result capture.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        first_d    = 1'b0;
        res_id_d   = res_id_q;
        res_sum_d  = res_sum_q;
        core_clear = 1'b0;
        core_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    core_clear = 1'b1;
                    owner_d    = winner;
                    last_d     = winner;
                    first_d    = 1'b1;
                    state_d    = StRun;
                end
            end
            StRun: begin
                core_step = 1'b1;
                if (core_last) begin
                    res_sum_d = core_x_nxt;
                    res_id_d  = owner_q;
                    state_d   = StResult;
                end
            end
            StResult: begin
                // req is not examined here, so the next accept is at least one cycle later.
                if (res_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state.
    always_comb begin
        gnt       = (state_q == StRun && first_q) ? (NUM_REQ'(1) << owner_q) : '0;
        busy      = (state_q != StIdle);
        res_valid = (state_q == StResult);
        res_id    = res_id_q;
        res_sum   = res_sum_q;
    end

    // State registers; reset points round-robin at requester 3 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            last_q    <= ID_W'(NUM_REQ - 1);
            owner_q   <= '0;
            first_q   <= 1'b0;
            res_id_q  <= '0;
            res_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            first_q   <= first_d;
            res_id_q  <= res_id_d;
            res_sum_q <= res_sum_d;
        end
    end

endmodule
